accum_cpu_sequencer: RTL and testbench
======================================

Name: accum_cpu_sequencer

Overview:
- Multi-cycle FSM that sequences the accumulator datapath: instruction fetch, decode, operand read, ALU execute, writeback, store and jump.
- Owns the PC and IR.
- Drives the memory request handshake, the ALU start/done handshake and the accumulator load strobes.
- Replaces purely combinational opcode decode with a cycle-accurate controller between instruction/data memory and the ALU/AC.

Parameters:
ADDR_W, 12, memory address width; instruction word = {opcode[3:0], addr[ADDR_W-1:0]}
RESET_PC, 0, PC value loaded on reset
ALU_TIMEOUT, 64, max cycles waiting for alu_done on multiply/divide before fault

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  level; sequencer leaves IDLE / continues only while high
mem_req  output  1  memory request, held until mem_ready
mem_we  output  1  1 = write (AC to mem_addr), 0 = read
mem_addr  output  ADDR_W  request address (PC on fetch, IR addr otherwise)
mem_rdata  input  4+ADDR_W  read data (instruction or operand)
mem_ready  input  1  completes current request this cycle
alu_op  output  4  IR opcode presented to ALU
alu_start  output  1  one-cycle pulse starting ALU operation
alu_done  input  1  ALU result valid (same cycle as alu_start allowed for single-cycle ops)
opnd_ld  output  1  latch mem_rdata into datapath operand register
ld_ac  output  1  one-cycle AC load strobe
ac_src  output  1  0 = ALU result into AC, 1 = operand register into AC
pc  output  ADDR_W  current PC
halted  output  1  sticky: undefined opcode or ALU timeout
fault  output  1  sticky: ALU timeout cause (halted also set)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pc=RESET_PC; IR=0; all strobes (mem_req, mem_we, alu_start, opnd_ld, ld_ac) 0; ac_src=0; alu_op=0; halted=0; fault=0; timeout counter=0.
- States: IDLE, FETCH, DECODE, OPRD, EXEC, WB, STORE, HALT.
- IDLE: run=1 -> FETCH next cycle.
- Checked at instruction boundaries only: run=0 when entering FETCH -> IDLE.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc.
  - On mem_ready: IR<=mem_rdata; pc<=pc+1, wrapping modulo 2^ADDR_W; -> DECODE.
- DECODE (1 cycle), by opcode:
  - 0000 -> STORE.
  - 0001-1001 (add, sub, mul, div, and, or, not, xor, xnor) -> OPRD.
  - 1111 -> pc<=IR addr; -> FETCH. Jump completes in DECODE, so fetch-to-fetch = fetch latency + 1 cycle.
  - 1010-1110 -> HALT, halted=1.
- OPRD: mem_req=1, mem_we=0, mem_addr=IR addr.
  - On mem_ready: opnd_ld=1 (same cycle); -> EXEC.
- EXEC:
  - alu_start=1 on the first EXEC cycle only.
  - Waits for alu_done; on alu_done -> WB.
  - Timeout counter increments each EXEC cycle without alu_done. Reaching ALU_TIMEOUT -> HALT, halted=1, fault=1.
- WB: ld_ac=1, ac_src=0 for one cycle -> FETCH.
- STORE: mem_req=1, mem_we=1, mem_addr=IR addr.
  - AC is not loaded.
  - On mem_ready -> FETCH.
- HALT: absorbing; only rst_n exits. All strobes 0.
- Memory handshake:
  - mem_req, mem_we and mem_addr are registered and held stable until the cycle mem_ready is sampled high.
  - mem_req drops the following cycle unless the next state issues a new request. Back-to-back FETCH after STORE deasserts mem_req for at least one cycle.
  - mem_ready while mem_req=0 is ignored.
- Minimum latencies, with mem_ready in the first request cycle and alu_done in the alu_start cycle:
  - ALU instruction: 5 cycles (FETCH, DECODE, OPRD, EXEC, WB).
  - Store: 3 cycles.
  - Jump: 2 cycles.
- alu_op = IR opcode, stable from DECODE through WB.
- Reset mid-request: mem_req drops asynchronously; no pending state is retained.

Test Plan:
- Reset then run=1; mem returns 0x1005 at addr 0, alu_done immediate -> OPRD mem_addr=0x005; ld_ac pulses 5 cycles after FETCH entry; pc=1.
- Opcode 0000 at addr 1 (0x0020) -> mem_req=1, mem_we=1, mem_addr=0x020, held 3 cycles while mem_ready is delayed 2 cycles; ld_ac never asserts.
- Jump 0xF0FF from pc=0xFFF -> pc wraps to 0 after fetch, then loads 0x0FF; next FETCH mem_addr=0x0FF.
- Multiply 0x3010 with alu_done delayed 10 cycles -> alu_start single pulse; ld_ac 1 cycle after alu_done. alu_done never returned -> halted=1, fault=1 after 64 EXEC cycles.
- Opcode 1100 fetched -> halted=1, fault=0; no further mem_req even with run=1.
- rst_n low during OPRD with mem_req=1 -> mem_req=0 immediately, pc=RESET_PC; after release with run=1, FETCH at addr 0.

Source files
------------

// File: rtl/accum_cpu_sequencer.sv
// accum_cpu_sequencer
// Multi-cycle controller for an accumulator CPU. It owns the PC and the
// instruction register and runs each instruction as a series of states:
// fetch, decode, operand read, ALU execute, writeback, store or jump.
// Instruction word = {opcode[3:0], addr[ADDR_W-1:0]}.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   run                   level enable, sampled at instruction boundaries
//   mem_req/mem_we/mem_addr  registered memory request, held until mem_ready
//   mem_rdata, mem_ready  memory read data and completion
//   alu_op, alu_start     opcode to the ALU and a one-cycle start pulse
//   alu_done              ALU result valid
//   opnd_ld               latch mem_rdata into the operand register
//   ld_ac, ac_src         accumulator load strobe and source select
//   pc                    current program counter
//   halted, fault         sticky halt flag and sticky ALU-timeout flag
module accum_cpu_sequencer #(
    parameter int          ADDR_W      = 12,
    parameter int unsigned RESET_PC    = 0,
    parameter int          ALU_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [ADDR_W+3:0]   mem_rdata,
    input  logic                mem_ready,
    output logic [3:0]          alu_op,
    output logic                alu_start,
    input  logic                alu_done,
    output logic                opnd_ld,
    output logic                ld_ac,
    output logic                ac_src,
    output logic [ADDR_W-1:0]   pc,
    output logic                halted,
    output logic                fault
);

    localparam int TMO_W = $clog2(ALU_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_OPRD, ST_EXEC, ST_WB, ST_STORE, ST_HALT
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W+3:0]   ir_q, ir_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                alu_start_q, alu_start_d;
    logic                ld_ac_q, ld_ac_d;
    logic                halted_q, halted_d;
    logic                fault_q, fault_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;

    logic                to_fetch_s;
    logic                fetch_gap_s;
    logic [ADDR_W-1:0]   fetch_pc_s;
    logic [3:0]          ir_op_s;
    logic [ADDR_W-1:0]   ir_addr_s;

    assign ir_op_s   = ir_q[ADDR_W+3 -: 4];
    assign ir_addr_s = ir_q[ADDR_W-1:0];

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        alu_start_d = 1'b0;
        ld_ac_d     = 1'b0;
        halted_d    = halted_q;
        fault_d     = fault_q;
        tmo_d       = tmo_q;
        to_fetch_s  = 1'b0;
        fetch_gap_s = 1'b0;
        fetch_pc_s  = pc_q;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    to_fetch_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (mem_req_q) begin
                    if (mem_ready) begin
                        ir_d      = mem_rdata;
                        pc_d      = pc_q + ADDR_W'(1);
                        mem_req_d = 1'b0;
                        state_d   = ST_DECODE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    // Entered with the request deliberately low (after a
                    // store); raise it now.
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = pc_q;
                end
            end
            ST_DECODE: begin
                case (ir_op_s)
                    4'd0: begin
                        state_d    = ST_STORE;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b1;
                        mem_addr_d = ir_addr_s;
                    end
                    4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin
                        state_d    = ST_OPRD;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = ir_addr_s;
                    end
                    4'd15: begin
                        pc_d       = ir_addr_s;
                        to_fetch_s = 1'b1;
                        fetch_pc_s = ir_addr_s;
                    end
                    default: begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end
                endcase
            end
            ST_OPRD: begin
                if (mem_ready) begin
                    mem_req_d   = 1'b0;
                    state_d     = ST_EXEC;
                    alu_start_d = 1'b1;
                    tmo_d       = '0;
                end else begin
                    state_d = ST_OPRD;
                end
            end
            ST_EXEC: begin
                if (alu_done) begin
                    state_d = ST_WB;
                    ld_ac_d = 1'b1;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_W'(ALU_TIMEOUT - 1)) begin
                    // This was the last allowed cycle without alu_done.
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                    fault_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_WB: begin
                to_fetch_s = 1'b1;
            end
            ST_STORE: begin
                if (mem_ready) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    to_fetch_s  = 1'b1;
                    // Leave one idle request cycle between store and fetch.
                    fetch_gap_s = 1'b1;
                end else begin
                    state_d = ST_STORE;
                end
            end
            ST_HALT: begin
                state_d   = ST_HALT;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
            default: begin
                state_d   = ST_HALT;
                halted_d  = 1'b1;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase

        // Instruction boundary: fetch the next instruction or park in IDLE.
        if (to_fetch_s) begin
            if (run) begin
                state_d    = ST_FETCH;
                mem_req_d  = ~fetch_gap_s;
                mem_we_d   = 1'b0;
                mem_addr_d = fetch_pc_s;
            end else begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        end else begin
            fetch_pc_s = fetch_pc_s;
        end
    end

    // State, PC, IR and registered output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= ADDR_W'(RESET_PC);
            ir_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            alu_start_q <= 1'b0;
            ld_ac_q     <= 1'b0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            alu_start_q <= alu_start_d;
            ld_ac_q     <= ld_ac_d;
            halted_q    <= halted_d;
            fault_q     <= fault_d;
            tmo_q       <= tmo_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign alu_op    = ir_op_s;
    assign alu_start = alu_start_q;
    assign ld_ac     = ld_ac_q;
    // Every AC load comes from the ALU result.
    assign ac_src    = 1'b0;
    assign pc        = pc_q;
    assign halted    = halted_q;
    assign fault     = fault_q;
    // Operand data is only valid in the cycle mem_ready is high, so the
    // latch strobe follows mem_ready directly.
    assign opnd_ld   = (state_q == ST_OPRD) & mem_req_q & mem_ready;

endmodule

// File: tb/tb_accum_cpu_sequencer.sv
module tb_accum_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        mem_req, mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ready = 1'b0;
    logic [3:0]  alu_op;
    logic        alu_start;
    logic        alu_done = 1'b0;
    logic        opnd_ld, ld_ac, ac_src;
    logic [11:0] pc;
    logic        halted, fault;

    int n_total = 0;
    int n_pass  = 0;

    accum_cpu_sequencer #(.ADDR_W(12), .RESET_PC(0), .ALU_TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done),
        .opnd_ld(opnd_ld), .ld_ac(ld_ac), .ac_src(ac_src),
        .pc(pc), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; alu_done = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    // Start from reset and complete the first fetch at address 0 with word w.
    task automatic fetch_first(input logic [15:0] w);
        do_reset();
        run = 1'b1;
        tick();                           // FETCH
        mem_ready = 1'b1; mem_rdata = w;
        tick();                           // DECODE
        mem_ready = 1'b0;
    endtask

    // ---------------- table of single-instruction decode vectors ----------
    typedef struct {
        logic [3:0]  op;
        logic        exp_req;
        logic        exp_we;
        logic [11:0] exp_addr;
        logic        exp_halted;
        logic [11:0] exp_pc;
    } vec_t;
    vec_t tv[16];

    // ---------------- random-run responder and event log ------------------
    logic [15:0] prog [0:4095];
    bit  auto_mode = 1'b0;
    int  wait_cnt = 0;
    bit  alu_busy = 1'b0;
    int  alu_cnt = 0;
    int  ev_q[$];
    int  exp_q[$];

    // Memory and ALU responders with random latency; logs every completed
    // memory transaction and every AC load as an event.
    always @(negedge clk) begin
        if (auto_mode) begin
            if (ld_ac) ev_q.push_back(32'h3000);
            if (mem_req) begin
                if (wait_cnt == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = prog[mem_addr];
                    ev_q.push_back(((mem_we ? 2 : 1) << 12) | int'(mem_addr));
                    wait_cnt = $urandom_range(0, 3);
                end else begin
                    mem_ready = 1'b0;
                    wait_cnt--;
                end
            end else begin
                mem_ready = 1'b0;
            end
            if (alu_start) begin
                alu_busy = 1'b1;
                alu_cnt  = $urandom_range(0, 4);
            end
            if (alu_busy && alu_cnt == 0) begin
                alu_done = 1'b1;
                alu_busy = 1'b0;
            end else begin
                alu_done = 1'b0;
                if (alu_busy) alu_cnt--;
            end
        end
    end

    initial begin
        logic [11:0] mpc;
        logic [15:0] ins;
        logic [3:0]  mop;
        logic [11:0] ma;
        int          n_ldac;
        bit          saw_req;

        // Expected decode outcome per opcode, fetched word {op, 0x0AB} at pc 0.
        for (int i = 0; i < 16; i++) begin
            tv[i].op = 4'(i);
            tv[i].exp_pc = 12'h001;
            tv[i].exp_halted = 1'b0;
            tv[i].exp_we = 1'b0;
            tv[i].exp_req = 1'b1;
            tv[i].exp_addr = 12'h0AB;
            if (i == 0) begin
                tv[i].exp_we = 1'b1;
            end else if (i == 15) begin
                tv[i].exp_pc = 12'h0AB;
            end else if (i >= 10) begin
                tv[i].exp_req = 1'b0;
                tv[i].exp_addr = 12'h000;
                tv[i].exp_halted = 1'b1;
            end
        end

        // Reset state, checked while reset is still asserted.
        rst_n = 1'b0;
        tick();
        chk("reset_strobes", {27'd0, mem_req, mem_we, alu_start, opnd_ld, ld_ac}, 32'd0);
        chk("reset_misc", {15'd0, ac_src, alu_op, pc}, 32'd0);
        chk("reset_flags", {30'd0, halted, fault}, 32'd0);

        // Decode table.
        for (int i = 0; i < 16; i++) begin
            fetch_first({tv[i].op, 12'h0AB});
            tick();
            chk($sformatf("decode_op%0h", i),
                {1'b0, mem_req, mem_we, mem_addr, halted, pc, alu_op},
                {1'b0, tv[i].exp_req, tv[i].exp_we, tv[i].exp_addr, tv[i].exp_halted,
                 tv[i].exp_pc, tv[i].op});
        end

        // ALU instruction 0x1005 with immediate alu_done.
        fetch_first(16'h1005);
        chk("alu_pc_after_fetch", {20'd0, pc}, 32'h001);
        tick();                                           // OPRD
        chk("oprd_req", {19'd0, mem_req, mem_we, mem_addr}, {19'd0, 1'b1, 1'b0, 12'h005});
        mem_ready = 1'b1; alu_done = 1'b1;
        #1;
        chk("opnd_ld", {31'd0, opnd_ld}, 32'd1);
        tick();                                           // EXEC
        mem_ready = 1'b0;
        chk("exec_start", {30'd0, alu_start, ld_ac}, 32'b10);
        tick();                                           // WB
        alu_done = 1'b0;
        chk("wb_ld_ac", {29'd0, ld_ac, ac_src, alu_start}, 32'b100);
        run = 1'b0;                                       // stop at boundary
        tick();
        chk("idle_after_run_low", {31'd0, mem_req}, 32'd0);
        run = 1'b1;
        tick();                                           // FETCH @1
        chk("fetch1", {19'd0, mem_req, ld_ac, mem_addr}, {19'd0, 1'b1, 1'b0, 12'h001});

        // Store 0x0020 with mem_ready delayed two cycles.
        mem_ready = 1'b1; mem_rdata = 16'h0020;
        tick();                                           // DECODE
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();                                       // STORE held
            chk($sformatf("store_hold%0d", k), {18'd0, mem_req, mem_we, ld_ac, mem_addr},
                {18'd0, 1'b1, 1'b1, 1'b0, 12'h020});
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("store_gap", {29'd0, mem_req, mem_we, ld_ac}, 32'd0);
        tick();
        chk("fetch2", {19'd0, mem_req, mem_we, mem_addr}, {19'd0, 1'b1, 1'b0, 12'h002});

        // Jump to 0xFFF, then jump 0xF0FF from there (pc wraps first).
        mem_ready = 1'b1; mem_rdata = 16'hFFFF;
        tick();                                           // DECODE
        mem_ready = 1'b0;
        tick();                                           // FETCH @FFF
        chk("jump_fff", {8'd0, mem_req, 7'd0, mem_addr, pc[3:0]}, {8'd0, 1'b1, 7'd0, 12'hFFF, 4'hF});
        mem_ready = 1'b1; mem_rdata = 16'hF0FF;
        tick();                                           // DECODE
        mem_ready = 1'b0;
        chk("pc_wrap", {20'd0, pc}, 32'h000);
        tick();                                           // FETCH @0FF
        chk("jump_target", {7'd0, mem_req, mem_addr, pc}, {7'd0, 1'b1, 12'h0FF, 12'h0FF});

        // Multiply 0x3010 with alu_done ten cycles after alu_start.
        mem_ready = 1'b1; mem_rdata = 16'h3010;
        tick();                                           // DECODE
        mem_ready = 1'b0;
        tick();                                           // OPRD
        mem_ready = 1'b1;
        tick();                                           // EXEC cycle 0
        mem_ready = 1'b0;
        chk("mul_start", {27'd0, alu_op, alu_start}, {27'd0, 4'h3, 1'b1});
        n_ldac = 0; saw_req = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (alu_start) saw_req = 1'b1;
            if (ld_ac) n_ldac++;
            if (i == 10) alu_done = 1'b1;
        end
        chk("mul_single_start", {31'd0, saw_req}, 32'd0);
        chk("mul_no_early_ld", n_ldac, 32'd0);
        tick();                                           // WB
        alu_done = 1'b0;
        chk("mul_wb", {31'd0, ld_ac}, 32'd1);
        tick();                                           // FETCH @100
        chk("fetch_100", {20'd0, mem_addr}, 32'h100);

        // Divide whose alu_done never comes: timeout after 64 EXEC cycles.
        mem_ready = 1'b1; mem_rdata = 16'h4001;
        tick();                                           // DECODE
        mem_ready = 1'b0;
        tick();                                           // OPRD
        mem_ready = 1'b1;
        tick();                                           // EXEC cycle 1
        mem_ready = 1'b0;
        for (int k = 2; k <= 64; k++) tick();
        chk("tmo_not_yet", {30'd0, halted, fault}, 32'd0);
        tick();
        chk("tmo_halt", {29'd0, halted, fault, mem_req}, 32'b110);

        // Undefined opcode 1100: halt without fault, no further requests.
        fetch_first(16'hC123);
        tick();
        chk("undef_halt", {30'd0, halted, fault}, 32'b10);
        saw_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (mem_req) saw_req = 1'b1;
        end
        chk("halt_absorbing", {30'd0, saw_req, halted}, 32'b01);

        // Reset asserted mid-OPRD drops the request immediately.
        fetch_first(16'h2077);
        tick();                                           // OPRD
        chk("pre_reset_req", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {19'd0, mem_req, pc}, 32'd0);
        tick();
        rst_n = 1'b1; run = 1'b1;
        tick();
        chk("refetch_0", {19'd0, mem_req, mem_addr}, {19'd0, 1'b1, 12'h000});

        // Random program against an instruction-level model.
        for (int a = 0; a < 4096; a++) begin
            int r;
            r = $urandom_range(0, 11);
            ins[11:0] = 12'($urandom_range(0, 4095));
            ins[15:12] = (r >= 10) ? 4'hF : 4'(r);
            prog[a] = ins;
        end
        mpc = 12'h000;
        while (exp_q.size() < 200) begin
            exp_q.push_back((1 << 12) | int'(mpc));
            ins = prog[mpc];
            mpc = mpc + 12'd1;
            mop = ins[15:12];
            ma  = ins[11:0];
            if (mop == 4'h0) begin
                exp_q.push_back((2 << 12) | int'(ma));
            end else if (mop == 4'hF) begin
                mpc = ma;
            end else begin
                exp_q.push_back((1 << 12) | int'(ma));
                exp_q.push_back(32'h3000);
            end
        end
        do_reset();
        wait_cnt = $urandom_range(0, 3);
        alu_busy = 1'b0;
        ev_q.delete();
        auto_mode = 1'b1;
        run = 1'b1;
        for (int c = 0; c < 8000 && ev_q.size() < 200; c++) tick();
        auto_mode = 1'b0;
        run = 1'b0; mem_ready = 1'b0; alu_done = 1'b0;
        chk("rand_event_count", {31'd0, ev_q.size() >= 200}, 32'd1);
        chk("rand_no_halt", {31'd0, halted}, 32'd0);
        for (int i = 0; i < 200 && i < ev_q.size(); i++)
            chk($sformatf("rand_ev%0d", i), ev_q[i], exp_q[i]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
